// File: rtl/emu_time_ctrl_pkg.sv
// Shared types for the emulation run-control blocks: command modes,
// controller states and their bit widths.
package emu_time_ctrl_pkg;

  localparam int CFG_MODE_W   = 2;
  localparam int CTRL_STATE_W = 3;

  // Command mode encoding as seen on cfg_mode.
  typedef enum logic [CFG_MODE_W-1:0] {
    MODE_FREE  = 2'd0,
    MODE_PAUSE = 2'd1,
    MODE_UNTIL = 2'd2,
    MODE_STEP  = 2'd3
  } cfg_mode_t;

  // Controller states; the encoding is visible on the dbg_state port.
  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_FREE  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_UNTIL = 3'd3,
    ST_STEP  = 3'd4,
    ST_HELD  = 3'd5
  } ctrl_state_t;

  // States in which the dt lane is forced to zero.
  function automatic logic is_stall_state(input ctrl_state_t s);
    return (s == ST_PAUSE) || (s == ST_HELD) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/emu_time_ctrl_clamp.sv
// dt_clamp: saturating (target - now) clamped to [0, dt_max].
// The difference is taken one bit wider than the time base, so it can
// never wrap.
module dt_clamp #(
  parameter int WIDTH      = 25,
  parameter int TIME_WIDTH = 39,
  parameter int DT_MAX     = 2**(WIDTH-1)-1
) (
  input  logic signed [TIME_WIDTH-1:0] target,
  input  logic signed [TIME_WIDTH-1:0] now,
  output logic signed [WIDTH-1:0]      dt
);

  localparam logic signed [TIME_WIDTH:0] DT_MAX_EXT = (TIME_WIDTH+1)'(DT_MAX);
  localparam logic signed [WIDTH-1:0]    DT_MAX_W   = WIDTH'(DT_MAX);

  logic signed [TIME_WIDTH:0] target_ext;
  logic signed [TIME_WIDTH:0] now_ext;
  logic signed [TIME_WIDTH:0] diff;

  // Sign-extend both operands, subtract, then saturate into [0, dt_max].
  always_comb begin
    target_ext = {target[TIME_WIDTH-1], target};
    now_ext    = {now[TIME_WIDTH-1], now};
    diff       = target_ext - now_ext;
    if (diff > DT_MAX_EXT) begin
      dt = DT_MAX_W;
    end else if (diff <= 0) begin
      dt = '0;
    end else begin
      dt = diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/emu_time_ctrl.sv
// emu_time_ctrl: run-control scheduler for the emulation time base.
// Produces one dt request lane for the time-advance min-reduction, so
// that emulated time can run freely, pause, run until an absolute target
// time, or run for a fixed number of emulation cycles.
//
// Command handshake: a command transfers on a rising emu_clk edge where
// cfg_valid && cfg_ready. cfg_ready is low only in LOAD, so at most one
// command is in flight. A host may hold cfg_valid and its payload stable
// until it sees the transfer; the payload is sampled only at the transfer.
module emu_time_ctrl
  import emu_time_ctrl_pkg::*;
#(
  parameter int WIDTH      = 25,
  parameter int TIME_WIDTH = 39,
  parameter int CNT_WIDTH  = 32,
  parameter int DT_MAX     = 2**(WIDTH-1)-1
) (
  input  logic                         emu_clk,
  input  logic                         emu_rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [1:0]                   cfg_mode,
  input  logic [TIME_WIDTH-1:0]        cfg_time,
  input  logic signed [TIME_WIDTH-1:0] emu_time,
  output logic signed [WIDTH-1:0]      dt_req,
  output logic                         emu_stall,
  output logic                         done,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam logic signed [WIDTH-1:0] DT_MAX_W = WIDTH'(DT_MAX);

  ctrl_state_t                  state_q, state_d;
  cfg_mode_t                    mode_q, mode_d;
  logic signed [TIME_WIDTH-1:0] target_q, target_d;
  logic [CNT_WIDTH-1:0]         count_q, count_d;
  logic                         done_q, done_d;

  logic                         cfg_fire;
  logic signed [WIDTH-1:0]      dt_until;

  assign cfg_fire = cfg_valid && cfg_ready;

  // Remaining distance to the UNTIL target, clamped to a legal dt.
  dt_clamp #(
    .WIDTH      (WIDTH),
    .TIME_WIDTH (TIME_WIDTH),
    .DT_MAX     (DT_MAX)
  ) u_dt_clamp (
    .target (target_q),
    .now    (emu_time),
    .dt     (dt_until)
  );

  // Next-state logic. An accepted command always wins over a completion
  // in the same cycle, which is why done_d is only raised in the else arm.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    count_d  = count_q;
    done_d   = 1'b0;
    if (cfg_fire) begin
      state_d  = ST_LOAD;
      mode_d   = cfg_mode_t'(cfg_mode);
      target_d = $signed(cfg_time);
      count_d  = cfg_time[CNT_WIDTH-1:0];
    end else begin
      case (state_q)
        ST_LOAD: begin
          case (mode_q)
            MODE_FREE:  state_d = ST_FREE;
            MODE_PAUSE: state_d = ST_PAUSE;
            MODE_UNTIL: begin
              if (target_q <= emu_time) begin
                state_d = ST_HELD;
                done_d  = 1'b1;
              end else begin
                state_d = ST_UNTIL;
              end
            end
            MODE_STEP: begin
              if (count_q == '0) begin
                state_d = ST_HELD;
                done_d  = 1'b1;
              end else begin
                state_d = ST_STEP;
              end
            end
            default: state_d = ST_FREE;
          endcase
        end
        ST_UNTIL: begin
          if (emu_time >= target_q) begin
            state_d = ST_HELD;
            done_d  = 1'b1;
          end
        end
        ST_STEP: begin
          count_d = count_q - CNT_WIDTH'(1);
          if (count_q == CNT_WIDTH'(1)) begin
            state_d = ST_HELD;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Controller registers; reset returns to free-running time.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q  <= ST_FREE;
      mode_q   <= MODE_FREE;
      target_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // dt lane: decoded from registered state and the registered emu_time.
  always_comb begin
    dt_req = '0;
    case (state_q)
      ST_FREE:  dt_req = DT_MAX_W;
      ST_STEP:  dt_req = DT_MAX_W;
      ST_UNTIL: dt_req = dt_until;
      default:  dt_req = '0;
    endcase
  end

  assign cfg_ready = (state_q != ST_LOAD);
  assign emu_stall = is_stall_state(state_q);
  assign busy      = (state_q == ST_UNTIL) || (state_q == ST_STEP);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_emu_time_ctrl.sv
// Bench for emu_time_ctrl with dt_max=1000. A small time-manager model
// advances emu_time by dt_req every cycle (or loads a forced value).
// The driver pushes the expected per-cycle outputs into exp_q; the
// monitor pops and compares on every falling edge.
module tb_emu_time_ctrl;
  import emu_time_ctrl_pkg::*;

  localparam int WIDTH      = 25;
  localparam int TIME_WIDTH = 39;
  localparam int CNT_WIDTH  = 32;
  localparam int DT_MAX     = 1000;
  localparam int W          = 32;

  logic                         emu_clk = 1'b0;
  logic                         emu_rst = 1'b1;
  logic                         cfg_valid = 1'b0;
  logic                         cfg_ready;
  logic [1:0]                   cfg_mode = 2'd0;
  logic [TIME_WIDTH-1:0]        cfg_time = '0;
  logic signed [TIME_WIDTH-1:0] emu_time = '0;
  logic signed [WIDTH-1:0]      dt_req;
  logic                         emu_stall;
  logic                         done;
  logic                         busy;
  logic [2:0]                   dbg_state;

  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;

  logic                         tm_force = 1'b0;
  logic signed [TIME_WIDTH-1:0] tm_val   = '0;

  emu_time_ctrl #(
    .WIDTH      (WIDTH),
    .TIME_WIDTH (TIME_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .DT_MAX     (DT_MAX)
  ) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_time  (cfg_time),
    .emu_time  (emu_time),
    .dt_req    (dt_req),
    .emu_stall (emu_stall),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  always #5 emu_clk = ~emu_clk;

  // Expected output word: {state, dt, stall, busy, done, ready}.
  function automatic logic [W-1:0] mk(input logic [2:0] st, input int dt, input logic dn);
    logic stall_e, busy_e, rdy_e;
    stall_e = (st == ST_PAUSE) || (st == ST_HELD) || (st == ST_LOAD);
    busy_e  = (st == ST_UNTIL) || (st == ST_STEP);
    rdy_e   = (st != ST_LOAD);
    return {st, WIDTH'(dt), stall_e, busy_e, dn, rdy_e};
  endfunction

  // Immediate check that all outputs hold their reset values.
  task automatic check_reset_outputs(input string label);
    logic [W-1:0] got_r, exp_r;
    got_r = {dbg_state, dt_req, emu_stall, busy, done, cfg_ready};
    exp_r = mk(ST_FREE, DT_MAX, 1'b0);
    checks++;
    if (got_r !== exp_r) begin
      failures++;
      $display("FAIL reset %s t=%0t got st=%0d dt=%0d stall/busy/done/rdy=%b",
               label, $time, got_r[31:29], $signed(got_r[28:4]), got_r[3:0]);
    end
  endtask

  // Driver: one emulation cycle. Advances the time-manager model, applies
  // the command inputs for the next edge and queues this cycle's outputs.
  task automatic cyc(input logic v, input logic [1:0] m, input int t,
                     input logic f, input int fv,
                     input logic [2:0] st, input int dt, input logic dn);
    logic signed [WIDTH-1:0] dt_seen;
    @(negedge emu_clk);
    dt_seen = dt_req;
    @(posedge emu_clk);
    #1;
    if (tm_force) emu_time = tm_val;
    else          emu_time = emu_time + TIME_WIDTH'(dt_seen);
    tm_force  = f;
    tm_val    = TIME_WIDTH'(fv);
    cfg_valid = v;
    cfg_mode  = m;
    cfg_time  = TIME_WIDTH'(t);
    exp_q.push_back(mk(st, dt, dn));
  endtask

  task automatic idle(input logic [2:0] st, input int dt, input logic dn);
    cyc(1'b0, 2'd0, 0, 1'b0, 0, st, dt, dn);
  endtask

  task automatic send(input logic [1:0] m, input int t, input logic f, input int fv,
                      input logic [2:0] st, input int dt);
    cyc(1'b1, m, t, f, fv, st, dt, 1'b0);
  endtask

  // Scoreboard monitor.
  logic [W-1:0] got_w, exp_w;
  always @(negedge emu_clk) begin
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      got_w = {dbg_state, dt_req, emu_stall, busy, done, cfg_ready};
      checks++;
      if (got_w !== exp_w) begin
        failures++;
        $display("FAIL outputs t=%0t got st=%0d dt=%0d stall/busy/done/rdy=%b need st=%0d dt=%0d stall/busy/done/rdy=%b",
                 $time, got_w[31:29], $signed(got_w[28:4]), got_w[3:0],
                 exp_w[31:29], $signed(exp_w[28:4]), exp_w[3:0]);
      end
    end
  end

  initial begin
    // Reset held: reset values.
    #1;
    check_reset_outputs("initial");
    idle(ST_FREE, DT_MAX, 0);
    idle(ST_FREE, DT_MAX, 0);
    emu_rst = 1'b0;

    // Free running, no command.
    repeat (3) idle(ST_FREE, DT_MAX, 0);

    // UNTIL 3500 from emu_time 0.
    send(MODE_UNTIL, 3500, 1'b1, 0, ST_FREE, DT_MAX);
    idle(ST_LOAD, 0, 0);
    idle(ST_UNTIL, 1000, 0);
    idle(ST_UNTIL, 1000, 0);
    idle(ST_UNTIL, 1000, 0);
    idle(ST_UNTIL, 500, 0);
    idle(ST_UNTIL, 0, 0);
    idle(ST_HELD, 0, 1);
    idle(ST_HELD, 0, 0);

    // STEP 4, then STEP 0.
    send(MODE_STEP, 4, 1'b0, 0, ST_HELD, 0);
    idle(ST_LOAD, 0, 0);
    repeat (4) idle(ST_STEP, DT_MAX, 0);
    idle(ST_HELD, 0, 1);
    idle(ST_HELD, 0, 0);
    send(MODE_STEP, 0, 1'b0, 0, ST_HELD, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_HELD, 0, 1);
    idle(ST_HELD, 0, 0);

    // UNTIL target already behind emu_time.
    send(MODE_UNTIL, 200, 1'b1, 500, ST_HELD, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_HELD, 0, 1);
    idle(ST_HELD, 0, 0);

    // UNTIL aborted by PAUSE, then FREE.
    send(MODE_UNTIL, 3500, 1'b1, 0, ST_HELD, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_UNTIL, 1000, 0);
    send(MODE_PAUSE, 0, 1'b0, 0, ST_UNTIL, 1000);
    idle(ST_LOAD, 0, 0);
    idle(ST_PAUSE, 0, 0);
    idle(ST_PAUSE, 0, 0);
    send(MODE_FREE, 0, 1'b0, 0, ST_PAUSE, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_FREE, DT_MAX, 0);
    idle(ST_FREE, DT_MAX, 0);

    // Clamp boundary: distance dt_max+1 splits into 1000 then 1.
    send(MODE_UNTIL, 1001, 1'b1, 0, ST_FREE, DT_MAX);
    idle(ST_LOAD, 0, 0);
    idle(ST_UNTIL, 1000, 0);
    idle(ST_UNTIL, 1, 0);
    idle(ST_UNTIL, 0, 0);
    idle(ST_HELD, 0, 1);

    // Completion and new command in the same cycle: command wins.
    send(MODE_UNTIL, 1000, 1'b1, 0, ST_HELD, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_UNTIL, 1000, 0);
    send(MODE_PAUSE, 0, 1'b0, 0, ST_UNTIL, 0);
    idle(ST_LOAD, 0, 0);
    idle(ST_PAUSE, 0, 0);
    send(MODE_STEP, 1, 1'b0, 0, ST_PAUSE, 0);
    idle(ST_LOAD, 0, 0);
    send(MODE_FREE, 0, 1'b0, 0, ST_STEP, DT_MAX);
    idle(ST_LOAD, 0, 0);
    idle(ST_FREE, DT_MAX, 0);

    // Asynchronous reset in the middle of STEP 7.
    send(MODE_STEP, 7, 1'b0, 0, ST_FREE, DT_MAX);
    idle(ST_LOAD, 0, 0);
    repeat (3) idle(ST_STEP, DT_MAX, 0);
    @(posedge emu_clk);
    #2;
    emu_rst = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.push_back(mk(ST_FREE, DT_MAX, 0));
    idle(ST_FREE, DT_MAX, 0);
    idle(ST_FREE, DT_MAX, 0);
    emu_rst = 1'b0;
    repeat (4) idle(ST_FREE, DT_MAX, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge emu_clk);
    @(posedge emu_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain wait expired with %0d expected entries pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/emu_time_ctrl.md
Name: emu_time_ctrl

Overview:
- Run-control scheduler for the emulation time base.
- Drives one dt request lane into the time-advance min-reduction, clamped so emulated time can be run freely, paused, run until an absolute target time, or run for a fixed number of emulation cycles.
- A host/debug side loads commands through a valid/ready handshake.
- Sits between the host control registers and the time manager; observes the current emu_time.

Parameters:
- width, 25, signed dt width; matches the time manager dt width.
- time_width, 39, signed emulation time width.
- cnt_width, 32, step-counter width (low bits of cfg_time in STEP mode).
- dt_max, 2**(width-1)-1, unconstrained dt request; must be > 0.

Ports:
- emu_clk  in  1  emulation clock.
- emu_rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  command ready.
- cfg_mode  in  2  0=FREE, 1=PAUSE, 2=UNTIL, 3=STEP.
- cfg_time  in  time_width  UNTIL: absolute target time; STEP: cycle count in [cnt_width-1:0]; ignored otherwise.
- emu_time  in  time_width signed  current time from the time manager (registered there).
- dt_req  out  width signed  this block's dt request lane.
- emu_stall  out  1  high when dt_req==0 by command (PAUSE/HELD/LOAD).
- done  out  1  one-cycle pulse on reaching the UNTIL target or STEP count exhaustion.
- busy  out  1  high in UNTIL or STEP.

Behaviour:
- Reset is asynchronous and active-high, affects all registers:
  - state=FREE, target=0, count=0, done=0, cfg_ready=1.
  - dt_req=dt_max, emu_stall=0, busy=0.
- States: FREE, PAUSE, LOAD, UNTIL, STEP, HELD.
- Handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready=1 in every state except LOAD.
  - On transfer, register mode/cfg_time and go to LOAD.
  - LOAD lasts exactly one cycle: dt_req=0, emu_stall=1.
  - A command accepted while in UNTIL/STEP aborts it with no done pulse.
- LOAD exit, by registered mode:
  - FREE -> FREE.
  - PAUSE -> PAUSE.
  - UNTIL: if target <= emu_time (signed) -> HELD with done=1; else -> UNTIL.
  - STEP: if count==0 -> HELD with done=1; else -> STEP.
- dt_req is combinational from registered state and emu_time (no loop, since emu_time is registered):
  - FREE: dt_max.
  - PAUSE, HELD, LOAD: 0.
  - UNTIL: diff = target - emu_time, computed in time_width+1 signed. dt_req = diff>dt_max ? dt_max : (diff<=0 ? 0 : diff).
  - STEP: dt_max.
- UNTIL: each cycle, if emu_time >= target -> HELD, done pulse in that transition cycle.
  - Because dt_req never exceeds the remaining distance, emu_time lands exactly on target unless another lane forces smaller steps.
  - Overshoot is impossible.
- STEP: count decrements each cycle in STEP; when count==1, the next state is HELD with done=1.
  - Total cycles with dt_req=dt_max equals the loaded count.
- HELD: stays until a new command is accepted. busy=0.
- done is registered; high only in the single cycle after the completion transition.
- Simultaneous completion and new command: the command wins; no done pulse.
- Reset mid-operation forces the reset values on the same edge asynchronously; any pending command is dropped.
- emu_stall = (state in {PAUSE, HELD, LOAD}).
- Reaching UNTIL with diff==0 in-cycle is treated as completion.

Decomposition:
- Package emu_time_ctrl_pkg:
  - cfg_mode_t enum: FREE/PAUSE/UNTIL/STEP.
  - ctrl_state_t enum: six states.
  - mode encoding constants.
- One sub-module: dt_clamp (combinational saturating target-minus-time clamp to [0, dt_max]); it is reused by other run-control blocks.

Test Plan:
1. Default params, dt_max=1000, release reset, no command -> dt_req=1000, emu_stall=0, cfg_ready=1, done=0 every cycle.
2. UNTIL, cfg_time=3500, from emu_time=0 (emu_time += dt_req each cycle) -> LOAD cycle dt_req=0; then dt_req 1000,1000,1000,500; emu_time=3500 exactly; one done pulse; then HELD with dt_req=0, emu_stall=1.
3. STEP, cfg_time=4 -> exactly 4 cycles with dt_req=1000; HELD; single done; busy high for those 4 cycles only. STEP with count 0 -> HELD plus done straight after LOAD.
4. UNTIL, target=200 while emu_time=500 -> HELD after LOAD, done=1, dt_req never nonzero.
5. UNTIL in progress, then PAUSE accepted mid-way -> LOAD, then PAUSE with dt_req=0; no done pulse. FREE afterwards -> dt_req=1000.
6. Assert emu_rst asynchronously mid-STEP (count=7) -> outputs return to reset values before the next edge; after release, state FREE, count=0, no done.
